score_display_seq: RTL and testbench
====================================

Name: score_display_seq

Overview:
- Parametrised successor to the score display path: accepts a binary score over a valid/ready handshake, converts it to BCD with a sequential double-dabble engine, and drives a time-multiplexed DIGITS-wide seven-segment display.
- Adds leading-zero blanking, overflow saturation, a display-blink mode and a configurable scan rate.
- Sits between game logic (score counter) and the board's anode/segment pins.

Parameters:
- BIN_W, 14, width of the binary score input.
- DIGITS, 4, number of seven-segment digits driven; must be 1..8.
- SCAN_DIV, 16, prescaler width; one digit advance every 2**SCAN_DIV clocks.
- BLINK_DIV, 25, blink toggle every 2**BLINK_DIV clocks.
- BLANK_LZ, 1, 1 = blank leading zeros (digit 0 is never blanked).

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous, active-low reset.
- score, input, BIN_W, binary value to display.
- score_valid, input, 1, score is presented.
- score_ready, output, 1, converter idle and able to accept.
- blink, input, 1, 1 = whole display flashes at the blink rate.
- dp_mask, input, DIGITS, per-digit decimal point enable (1 = lit).
- overflow, output, 1, last accepted score exceeded 10**DIGITS-1.
- an, output, DIGITS, anode enables, active-low.
- seg, output, 7, segments {g,f,e,d,c,b,a}, active-low.
- dp, output, 1, decimal point, active-low.

Behaviour:
- Reset (reset low, async) values:
  - an all 1, seg 7'h7F, dp 1.
  - score_ready 1, overflow 0.
  - Display BCD register 0; prescaler, digit index and blink phase 0; FSM IDLE.
- Handshake: a transfer occurs on a rising edge with score_valid and score_ready both 1. score_ready is 1 only in IDLE. A valid asserted while busy is not accepted; the producer holds it.
- FSM:
  - IDLE: on transfer, capture score into shift register, clear the BCD work register, set iteration count = BIN_W, and go to SHIFT. Also latch sat = (score > 10**DIGITS-1).
  - SHIFT: each cycle, add 3 to every work nibble >= 5, then shift {bcd,bin} left by 1. Decrement the count; after BIN_W SHIFT cycles go to DONE.
  - DONE: for one cycle, copy the work register to the display register (all nibbles 9 if sat). Set overflow = sat, then go to IDLE.
- Latency: display register updates BIN_W+1 cycles after the accepting edge; score_ready returns 1 the cycle after DONE. Back-to-back throughput is one score per BIN_W+2 cycles.
- Work register width is 4*DIGITS; high-order bits lost on overflow are irrelevant because of saturation.
- The display register holds its value between conversions; the old value stays visible during conversion.
- Scanner:
  - The prescaler free-runs. On terminal count, the digit index increments, wrapping DIGITS-1 -> 0.
  - an has exactly one bit low: bit[index].
  - seg shows the encoded nibble[index]; dp = ~dp_mask[index].
  - Outputs are registered, so they change one cycle after the index changes.
- Blanking:
  - With BLANK_LZ=1, digit i>0 is blank (seg 7'h7F, dp still per mask) if nibble i and every higher nibble are 0. Value 0 shows a single "0".
  - Blank nibble codes 10..15 never occur; the encoder maps them to 7'h7F.
- Blink: while blink=1 and blink phase=1, an is forced all 1. The blink phase counter runs regardless of blink.
- Reset mid-conversion aborts: FSM returns to IDLE, and display register and overflow clear.

Decomposition:
- Package sevseg_pkg:
  - state_t enum (IDLE, SHIFT, DONE).
  - function seg_encode(4-bit) -> 7-bit active-low pattern.
  - function pow10(n) for the saturation constant.
  - constant SEG_BLANK = 7'h7F.
- Sub-module bin_to_bcd_seq: the FSM, handshake and double-dabble engine, with outputs bcd, bcd_load and sat.
- Top level: scanner, blanking, blink and output registers.

Test Plan:
- Reset, then score=0 accepted: an cycles 1110,1101,1011,0111 every 2**SCAN_DIV clocks. seg=7'h40 ("0") on digit 0 only; digits 1..3 show 7'h7F.
- score=1234: display register becomes 0x1234 exactly 15 cycles after acceptance. score_ready is 0 for those cycles, and digits 3..0 show 1,2,3,4 (7'h79,7'h24,7'h30,7'h19).
- score=12000 (>9999): display becomes 0x9999 and overflow=1. The next score=42 clears overflow and shows "  42".
- score_valid held while busy with a second value 77: it is accepted only after score_ready rises, and the first value 1234 is shown before 77.
- reset pulsed low 5 cycles into a conversion: outputs return to reset values immediately (async), and no stale load occurs after release.
- blink=1 with BLINK_DIV=3, dp_mask=4'b0100: an is all 1 for alternating 8-cycle windows; dp is 0 only when index=2 and not blinked off.

Source files
------------

// File: rtl/sevseg_pkg.sv
// Shared types and helpers for the score display path:
// converter FSM states, segment encoding and decimal limits.
package sevseg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a}; non-decimal nibbles stay dark
    function automatic logic [6:0] seg_encode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter with a valid/ready input
// and a one-cycle load strobe carrying the (saturated) BCD result.
module bin_to_bcd_seq
    import sevseg_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [BIN_W-1:0]      score,
    input  logic                  score_valid,
    output logic                  score_ready,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  bcd_load,
    output logic                  sat
);

    localparam int WW = 4 * DIGITS;
    localparam int CW = $clog2(BIN_W + 1);
    localparam logic [63:0] MAXV = pow10(DIGITS) - 64'd1;

    state_t          state_q;
    logic [BIN_W-1:0] bin_q;
    logic [WW-1:0]   work_q;
    logic [WW-1:0]   work_d;
    logic [CW-1:0]   cnt_q;
    logic            sat_q;

    always_comb begin
        work_d = work_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (work_q[4*i +: 4] >= 4'd5) begin
                work_d[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            bin_q   <= '0;
            work_q  <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (score_valid) begin
                        bin_q   <= score;
                        work_q  <= '0;
                        cnt_q   <= CW'(BIN_W);
                        sat_q   <= (64'(score) > MAXV);
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    {work_q, bin_q} <= {work_d, bin_q} << 1;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign score_ready = (state_q == IDLE);
    assign bcd_load    = (state_q == DONE);
    assign bcd         = sat_q ? {DIGITS{4'h9}} : work_q;
    assign sat         = sat_q;

endmodule

// File: rtl/score_display_seq.sv
// Score-to-seven-segment path: converter plus multiplexed scanner
// with leading-zero blanking, blink and registered pin drivers.
module score_display_seq
    import sevseg_pkg::*;
#(
    parameter int BIN_W     = 14,
    parameter int DIGITS    = 4,
    parameter int SCAN_DIV  = 16,
    parameter int BLINK_DIV = 25,
    parameter int BLANK_LZ  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [BIN_W-1:0]  score,
    input  logic              score_valid,
    output logic              score_ready,
    input  logic              blink,
    input  logic [DIGITS-1:0] dp_mask,
    output logic              overflow,
    output logic [DIGITS-1:0] an,
    output logic [6:0]        seg,
    output logic              dp
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [4*DIGITS-1:0] bcd;
    logic                bcd_load;
    logic                sat;

    logic [4*DIGITS-1:0] disp_q;
    logic                ovf_q;
    logic [SCAN_DIV-1:0] presc_q;
    logic [IW-1:0]       idx_q;
    logic [BLINK_DIV-1:0] bcnt_q;
    logic                bph_q;
    logic [DIGITS-1:0]   an_q;
    logic [DIGITS-1:0]   an_d;
    logic [6:0]          seg_q;
    logic [6:0]          seg_d;
    logic                dp_q;
    logic                dp_d;
    logic [DIGITS-1:0]   blank;
    logic                zrun;
    logic [3:0]          nib;
    logic                off;

    bin_to_bcd_seq #(
        .BIN_W  (BIN_W),
        .DIGITS (DIGITS)
    ) u_conv (
        .clk         (clk),
        .reset       (reset),
        .score       (score),
        .score_valid (score_valid),
        .score_ready (score_ready),
        .bcd         (bcd),
        .bcd_load    (bcd_load),
        .sat         (sat)
    );

    // A digit is blank when it and everything above it is zero
    always_comb begin
        zrun  = 1'b1;
        blank = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zrun = zrun & (disp_q[4*i +: 4] == 4'h0);
            if (i > 0 && BLANK_LZ != 0) begin
                blank[i] = zrun;
            end
        end
        nib   = disp_q[4*int'(idx_q) +: 4];
        off   = blink & bph_q;
        an_d  = off ? '1 : ~(DIGITS'(1) << idx_q);
        seg_d = blank[idx_q] ? SEG_BLANK : seg_encode(nib);
        dp_d  = off | ~dp_mask[idx_q];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            disp_q  <= '0;
            ovf_q   <= 1'b0;
            presc_q <= '0;
            idx_q   <= '0;
            bcnt_q  <= '0;
            bph_q   <= 1'b0;
            an_q    <= '1;
            seg_q   <= SEG_BLANK;
            dp_q    <= 1'b1;
        end else begin
            presc_q <= presc_q + SCAN_DIV'(1);
            if (&presc_q) begin
                idx_q <= (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
            end
            bcnt_q <= bcnt_q + BLINK_DIV'(1);
            if (&bcnt_q) begin
                bph_q <= ~bph_q;
            end
            if (bcd_load) begin
                disp_q <= bcd;
                ovf_q  <= sat;
            end
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    assign overflow = ovf_q;
    assign an       = an_q;
    assign seg      = seg_q;
    assign dp       = dp_q;

endmodule

// File: tb/tb_score_display_seq.sv
// Directed and random scores against a decimal reference model of
// the handshake, conversion latency, saturation and scanned display.
module tb_score_display_seq;

    localparam int BIN_W = 14;
    localparam int DIGITS = 4;
    localparam int SCAN = 2;
    localparam int BLNK = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [13:0] score = '0;
    logic        score_valid = 1'b0;
    logic        blink = 1'b0;
    logic [3:0]  dp_mask = '0;
    logic        score_ready;
    logic        overflow;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int          vecs = 0;
    int          errs = 0;
    int          shown = 0;
    logic        ovf_e = 1'b0;
    int unsigned cyc = 0;

    logic [6:0] pat [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                             7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    score_display_seq #(
        .BIN_W     (BIN_W),
        .DIGITS    (DIGITS),
        .SCAN_DIV  (SCAN),
        .BLINK_DIV (BLNK),
        .BLANK_LZ  (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .score       (score),
        .score_valid (score_valid),
        .score_ready (score_ready),
        .blink       (blink),
        .dp_mask     (dp_mask),
        .overflow    (overflow),
        .an          (an),
        .seg         (seg),
        .dp          (dp)
    );

    always #5 clk = ~clk;

    // Clock edges seen since reset was last released
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic int p10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out();
        int       idx;
        int       d;
        logic     off;
        logic [3:0] an_e;
        logic [6:0] seg_e;
        logic     dp_e;
        if (cyc == 0) begin
            an_e  = 4'hF;
            seg_e = 7'h7F;
            dp_e  = 1'b1;
        end else begin
            idx   = int'(((cyc - 1) >> SCAN) % DIGITS);
            off   = blink && ((((cyc - 1) >> BLNK) & 1) != 0);
            d     = (shown / p10(idx)) % 10;
            an_e  = off ? 4'hF : ~(4'b0001 << idx);
            seg_e = (idx > 0 && shown < p10(idx)) ? 7'h7F : pat[d];
            dp_e  = off ? 1'b1 : ~dp_mask[idx];
        end
        chk("an", an, an_e);
        chk("seg", seg, seg_e);
        chk("dp", dp, dp_e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send(input int v, input bit hold, input int nv);
        int n = 0;
        score = 14'(v);
        score_valid = 1'b1;
        while (!score_ready && n < 40) begin
            step();
            n++;
        end
        chk("ready_wait", score_ready, 1);
        step();
        if (hold) score = 14'(nv);
        else      score_valid = 1'b0;
        chk("busy", score_ready, 0);
        for (int j = 1; j < 15; j++) begin
            step();
            chk("busy", score_ready, 0);
        end
        chk("ovf_old", overflow, ovf_e);
        step();
        chk("ready_back", score_ready, 1);
        ovf_e = (v > 9999);
        chk("ovf", overflow, ovf_e);
        shown = (v > 9999) ? 9999 : v;
    endtask

    initial begin
        #1 reset = 1'b0;
        #2;
        check_out();
        chk("rst_ready", score_ready, 1);
        chk("rst_ovf", overflow, 0);
        steps(2);
        reset = 1'b1;

        send(0, 1'b0, 0);
        steps(20);
        send(1234, 1'b0, 0);
        steps(16);
        send(12000, 1'b0, 0);
        steps(16);

        // abort a conversion with reset
        score = 14'd5678;
        score_valid = 1'b1;
        step();
        score_valid = 1'b0;
        steps(5);
        reset = 1'b0;
        shown = 0;
        ovf_e = 1'b0;
        #1;
        check_out();
        chk("abort_ready", score_ready, 1);
        chk("abort_ovf", overflow, 0);
        steps(2);
        reset = 1'b1;
        steps(24);
        chk("no_stale_ovf", overflow, 0);

        send(42, 1'b0, 0);
        steps(16);
        send(1234, 1'b1, 77);
        send(77, 1'b0, 0);
        steps(16);
        send(9999, 1'b0, 0);
        steps(16);
        send(10000, 1'b0, 0);
        steps(16);

        blink = 1'b1;
        dp_mask = 4'b0100;
        steps(48);
        blink = 1'b0;

        for (int k = 0; k < 25; k++) begin
            dp_mask = 4'($urandom);
            blink = 1'($urandom_range(0, 1));
            send(int'($urandom_range(0, 16383)), 1'b0, 0);
            steps(int'($urandom_range(4, 20)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
